// File: rtl/output_delta_unit_pkg.sv
// -----------------------------------------------------------------------------
// output_delta_unit_pkg
// Fixed-point constants shared by the FF, BP and UP processor sets and by the
// output-layer error stage, plus the beat-phase type used to decode the beat
// counter of output_delta_unit.
//   FX_INT_BITS / FX_FRAC_BITS : Q-format split (sign bit not counted)
//   FX_WIDTH                   : 1 + FX_INT_BITS + FX_FRAC_BITS
//   FX_ONE                     : 1.0 in the Q-format
//   FX_MAX / FX_MIN            : signed saturation limits of a FX_WIDTH word
// -----------------------------------------------------------------------------
package output_delta_unit_pkg;

    localparam int FX_INT_BITS  = 5;
    localparam int FX_FRAC_BITS = 10;
    localparam int FX_WIDTH     = 1 + FX_INT_BITS + FX_FRAC_BITS;

    localparam logic signed [FX_WIDTH-1:0] FX_ONE = FX_WIDTH'(1 << FX_FRAC_BITS);
    localparam logic signed [FX_WIDTH-1:0] FX_MAX = {1'b0, {(FX_WIDTH-1){1'b1}}};
    localparam logic signed [FX_WIDTH-1:0] FX_MIN = {1'b1, {(FX_WIDTH-1){1'b0}}};

    // Role of the beat currently presented, decoded from the beat counter.
    // PH_SINGLE covers a sample that fits in one beat (FIRST and LAST at once).
    typedef enum logic [1:0] {
        PH_FIRST  = 2'd0,
        PH_ACCUM  = 2'd1,
        PH_LAST   = 2'd2,
        PH_SINGLE = 2'd3
    } phase_e;

    // Word width implied by an integer/fraction split.
    function automatic int fx_width(input int int_bits, input int frac_bits);
        return 1 + int_bits + frac_bits;
    endfunction

    // Decode the beat counter into the phase of the current beat.
    function automatic phase_e beat_phase(input int bc, input int nbeats);
        if (nbeats == 1)           return PH_SINGLE;
        else if (bc == 0)          return PH_FIRST;
        else if (bc == nbeats - 1) return PH_LAST;
        else                       return PH_ACCUM;
    endfunction

endpackage

// File: rtl/output_delta_unit_lane.sv
// -----------------------------------------------------------------------------
// output_delta_lane
// Purely combinational error computation for one output neuron:
//   deltan = sat( ((a - y) * sp) >>> frac_bits ),  y = 1.0 if this neuron is
//   the labelled class, else 0.
// Ports
//   i_act      activation a (signed Q-format)
//   i_sp       sigmoid prime of the same neuron
//   i_is_label 1 when this neuron index equals the effective label
//   o_deltan   saturated delta for the BP/UP sets
//   o_act      activation passed through for the argmax compare tree
// -----------------------------------------------------------------------------
module output_delta_lane
    import output_delta_unit_pkg::*;
#(
    parameter int width     = FX_WIDTH,
    parameter int frac_bits = FX_FRAC_BITS
) (
    input  logic signed [width-1:0] i_act,
    input  logic signed [width-1:0] i_sp,
    input  logic                    i_is_label,
    output logic signed [width-1:0] o_deltan,
    output logic signed [width-1:0] o_act
);

    // Full product width: (width+1)-bit difference times width-bit sp, with
    // one spare bit so no intermediate can wrap.
    localparam int PW = 2 * width + 2;

    localparam logic signed [width:0]    Y_ONE  = (width+1)'(1) << frac_bits;
    localparam logic signed [PW-1:0]     SAT_HI = {{(PW-width+1){1'b0}}, {(width-1){1'b1}}};
    localparam logic signed [PW-1:0]     SAT_LO = {{(PW-width+1){1'b1}}, {(width-1){1'b0}}};
    localparam logic signed [width-1:0]  OUT_HI = {1'b0, {(width-1){1'b1}}};
    localparam logic signed [width-1:0]  OUT_LO = {1'b1, {(width-1){1'b0}}};

    function automatic logic signed [width-1:0] sat_to_width(input logic signed [PW-1:0] v);
        if (v > SAT_HI)      return OUT_HI;
        else if (v < SAT_LO) return OUT_LO;
        else                 return v[width-1:0];
    endfunction

    logic signed [width:0]  w_act_ext;
    logic signed [width:0]  w_y;
    logic signed [width:0]  w_diff;
    logic signed [PW-1:0]   w_diff_ext;
    logic signed [PW-1:0]   w_sp_ext;
    logic signed [PW-1:0]   w_prod;
    logic signed [PW-1:0]   w_shift;

    // One extra bit on the subtract: a in [0,1) minus 1.0 stays in range.
    assign w_act_ext  = {i_act[width-1], i_act};
    assign w_y        = i_is_label ? Y_ONE : '0;
    assign w_diff     = w_act_ext - w_y;

    assign w_diff_ext = {{(PW-width-1){w_diff[width]}}, w_diff};
    assign w_sp_ext   = {{(PW-width){i_sp[width-1]}}, i_sp};
    assign w_prod     = w_diff_ext * w_sp_ext;

    // Arithmetic shift truncates toward -inf.
    assign w_shift    = w_prod >>> frac_bits;

    assign o_deltan   = sat_to_width(w_shift);
    assign o_act      = i_act;

endmodule

// File: rtl/output_delta_unit.sv
// -----------------------------------------------------------------------------
// output_delta_unit
// Output-layer error stage between the last FF processor set and the first BP
// processor set. Each accepted beat carries L = z/fi neurons; a sample is
// B = n/L beats. Emits deltan = (a - y) * f'(s) one cycle after each beat and
// tracks the argmax neuron to report the predicted class per sample.
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   in_valid          beat valid; no backpressure, gaps allowed anywhere
//   sigmoid_package   L activations, lane k = neuron bc*L+k
//   sp_package        L sigmoid primes, same lane order
//   label             true class, sampled only on beat 0
//   deltan_package    L registered deltas, held while deltan_valid = 0
//   deltan_valid      in_valid delayed one cycle
//   sample_done       one-cycle pulse the cycle after the last beat
//   predicted         argmax neuron of the last completed sample
//   correct           predicted == label latched for that sample
// -----------------------------------------------------------------------------
module output_delta_unit
    import output_delta_unit_pkg::*;
#(
    parameter int fi        = 4,
    parameter int z         = 8,
    parameter int n         = 8,
    parameter int width     = FX_WIDTH,
    parameter int int_bits  = FX_INT_BITS,
    parameter int frac_bits = FX_FRAC_BITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [width*(z/fi)-1:0]     sigmoid_package,
    input  logic [width*(z/fi)-1:0]     sp_package,
    input  logic [$clog2(n)-1:0]        label,
    output logic [width*(z/fi)-1:0]     deltan_package,
    output logic                        deltan_valid,
    output logic                        sample_done,
    output logic [$clog2(n)-1:0]        predicted,
    output logic                        correct
);

    localparam int L   = z / fi;
    localparam int B   = n / L;
    localparam int LW  = $clog2(n);
    localparam int BCW = (B > 1) ? $clog2(B) : 1;

    generate
        if (n % L != 0) begin : g_bad_n
            $error("output_delta_unit: n must be a multiple of z/fi");
        end
        if (width != fx_width(int_bits, frac_bits)) begin : g_bad_width
            $error("output_delta_unit: width must equal 1 + int_bits + frac_bits");
        end
    endgenerate

    // Beat counter / phase
    logic [BCW-1:0]          r_bc;
    logic [BCW-1:0]          w_bc_next;
    phase_e                  w_phase;
    logic                    w_sample_end;

    // Sample context
    logic [LW-1:0]           r_label;
    logic [LW-1:0]           w_label_eff;
    logic signed [width-1:0] r_max;
    logic [LW-1:0]           r_max_idx;

    // Lane fan-out
    logic [31:0]             w_base;
    logic [LW-1:0]           w_lane_idx [L];
    logic signed [width-1:0] w_lane_act [L];
    logic [width*L-1:0]      w_deltan;

    // Compare tree results
    logic signed [width-1:0] w_beat_max;
    logic [LW-1:0]           w_beat_idx;
    logic signed [width-1:0] w_cand_max;
    logic [LW-1:0]           w_cand_idx;

    // Output registers
    logic [width*L-1:0]      r_deltan_p1;
    logic                    r_vld_p1;
    logic                    r_done_p1;
    logic [LW-1:0]           r_pred;
    logic                    r_correct;

    assign w_phase      = beat_phase(int'(r_bc), B);
    assign w_sample_end = in_valid && (w_phase == PH_LAST || w_phase == PH_SINGLE);

    // Beat 0 uses the live label so y is right before it has been latched.
    assign w_label_eff  = (r_bc == '0) ? label : r_label;

    assign w_base       = 32'(r_bc) * 32'(L);

    // ---- stage 0: per-lane combinational delta -------------------------------
    genvar g;
    generate
        for (g = 0; g < L; g++) begin : g_lane
            assign w_lane_idx[g] = LW'(w_base + 32'(g));

            output_delta_lane #(
                .width     (width),
                .frac_bits (frac_bits)
            ) u_lane (
                .i_act      (sigmoid_package[g*width +: width]),
                .i_sp       (sp_package[g*width +: width]),
                .i_is_label (w_lane_idx[g] == w_label_eff),
                .o_deltan   (w_deltan[g*width +: width]),
                .o_act      (w_lane_act[g])
            );
        end
    endgenerate

    // Lane scan from lane 0 with a strict compare keeps the lowest index on ties.
    always_comb begin
        w_beat_max = w_lane_act[0];
        w_beat_idx = w_lane_idx[0];
        for (int k = 1; k < L; k++) begin
            if (w_lane_act[k] > w_beat_max) begin
                w_beat_max = w_lane_act[k];
                w_beat_idx = w_lane_idx[k];
            end
        end
    end

    // Later beats only hold higher indices, so a strict compare against the
    // running max also resolves cross-beat ties to the lowest index.
    always_comb begin
        w_cand_max = w_beat_max;
        w_cand_idx = w_beat_idx;
        if ((w_phase == PH_ACCUM || w_phase == PH_LAST) && !(w_beat_max > r_max)) begin
            w_cand_max = r_max;
            w_cand_idx = r_max_idx;
        end
    end

    always_comb begin
        w_bc_next = r_bc;
        if (in_valid) begin
            if (w_phase == PH_LAST || w_phase == PH_SINGLE) w_bc_next = '0;
            else                                            w_bc_next = r_bc + BCW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_bc <= '0;
        else       r_bc <= w_bc_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_label   <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
        end else if (in_valid) begin
            if (r_bc == '0) r_label <= label;
            if (w_sample_end) begin
                r_max     <= '0;
                r_max_idx <= '0;
            end else begin
                r_max     <= w_cand_max;
                r_max_idx <= w_cand_idx;
            end
        end
    end

    // ---- stage 1: registered outputs -----------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deltan_p1 <= '0;
            r_vld_p1    <= 1'b0;
            r_done_p1   <= 1'b0;
            r_pred      <= '0;
            r_correct   <= 1'b0;
        end else begin
            r_vld_p1  <= in_valid;
            r_done_p1 <= w_sample_end;
            if (in_valid) r_deltan_p1 <= w_deltan;
            if (w_sample_end) begin
                r_pred    <= w_cand_idx;
                r_correct <= (w_cand_idx == w_label_eff);
            end
        end
    end

    assign deltan_package = r_deltan_p1;
    assign deltan_valid   = r_vld_p1;
    assign sample_done    = r_done_p1;
    assign predicted      = r_pred;
    assign correct        = r_correct;

endmodule
